// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one baud-clocked UART transmitter between two byte sources.
// Optional build macro UART_TX_SCHED_CRLF_EN appends 0x0A after every successfully sent 0x0D.
module uart_tx_sched #(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned CW             = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic [7:0] tx_data,
  output logic       tx_ena,
  input  logic       tx_sent,
  output logic       busy,
  output logic       last_grant,
  output logic       err
);

  localparam int unsigned DW = 8;
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
`ifdef UART_TX_SCHED_CRLF_EN
  localparam logic [DW-1:0] CHAR_CR = DW'(8'h0D);
  localparam logic [DW-1:0] CHAR_LF = DW'(8'h0A);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2,
    S_GAP     = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic            last_grant_q, last_grant_d;
  logic            tx_ena_q, busy_q, err_q, err_d;
  logic            sync1_q, sent_s_q, sent_q;
  logic            sent_rise;
  logic            idle_c;
`ifdef UART_TX_SCHED_CRLF_EN
  logic            timed_out_q, timed_out_d;
`endif

  // tx_sent comes from the baud domain: two-flop synchronizer plus edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sent_s_q <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      sync1_q  <= tx_sent;
      sent_s_q <= sync1_q;
      sent_q   <= sent_s_q;
    end
  end

  assign sent_rise = sent_s_q & ~sent_q;

  // Grant goes to whoever was not served last when both ask at once
  assign idle_c  = (state_q == S_IDLE) & ~reset;
  assign a_ready = idle_c & a_valid & (~b_valid | last_grant_q);
  assign b_ready = idle_c & b_valid & (~a_valid | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    last_grant_d = last_grant_q;
    err_d        = 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
    timed_out_d  = timed_out_q;
`endif
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (a_ready) begin
          tx_data_d    = a_data;
          last_grant_d = 1'b0;
          cnt_d        = '0;
          state_d      = S_ASSERT;
`ifdef UART_TX_SCHED_CRLF_EN
          timed_out_d  = 1'b0;
`endif
        end else if (b_ready) begin
          tx_data_d    = b_data;
          last_grant_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_ASSERT;
`ifdef UART_TX_SCHED_CRLF_EN
          timed_out_d  = 1'b0;
`endif
        end
      end

      // ena is held as a level; sent beats a coincident timeout
      S_ASSERT: begin
        cnt_d = cnt_inc;
        if (sent_rise) begin
          state_d = S_RELEASE;
        end else if (cnt_q >= TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
`ifdef UART_TX_SCHED_CRLF_EN
          timed_out_d = 1'b1;
`endif
        end
      end

      S_RELEASE: begin
        if (!sent_s_q) begin
          cnt_d = '0;
`ifdef UART_TX_SCHED_CRLF_EN
          if ((tx_data_q == CHAR_CR) && !timed_out_q) begin
            tx_data_d = CHAR_LF;
            state_d   = S_ASSERT;
          end else begin
            state_d   = S_GAP;
          end
`else
          state_d = S_GAP;
`endif
        end
      end

      S_GAP: begin
        if (cnt_q >= GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      last_grant_q <= 1'b1;
      tx_ena_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      last_grant_q <= last_grant_d;
      tx_ena_q     <= (state_d == S_ASSERT);
      busy_q       <= (state_d != S_IDLE);
      err_q        <= err_d;
    end
  end

`ifdef UART_TX_SCHED_CRLF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timed_out_q <= 1'b0;
    end else begin
      timed_out_q <= timed_out_d;
    end
  end
`endif

  assign tx_data    = tx_data_q;
  assign tx_ena     = tx_ena_q;
  assign busy       = busy_q;
  assign last_grant = last_grant_q;
  assign err        = err_q;

endmodule
